seq_detector_param: RTL
=======================

Name: seq_detector_param

Overview:
- Parameterised serial bit-pattern detector: the successor to the fixed 1011 Mealy non-overlapping detector.
- Pattern width and value are set by parameters. Overlapping vs non-overlapping mode is selected at run time.
- Provides an input qualifier, Mealy and Moore match outputs, and a saturating match counter.
- Sits on a serial bit stream ahead of framing/sync logic that needs pattern hits and hit statistics.

Parameters:
- PAT_WIDTH, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1011, PAT_WIDTH-bit pattern; PATTERN[PAT_WIDTH-1] is the first bit received.
- CNT_WIDTH, 8, width of match_count.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in  input  1  serial data bit
- in_valid  input  1  qualifies in; when low, the cycle is ignored
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping
- cnt_clr  input  1  synchronous clear of match_count
- out  output  1  Mealy match flag, combinational from state, in and in_valid
- out_moore  output  1  registered match flag, high the cycle after a match
- match_count  output  CNT_WIDTH  number of matches since reset/clear, saturating
- state  output  clog2(PAT_WIDTH)  current matched-prefix length, 0..PAT_WIDTH-1 (debug)

Behaviour:
- Reset (rst=1 at clock edge): state=0, out_moore=0, match_count=0.
- While rst=1, out is forced to 0.
- State s = number of leading pattern bits matched so far. Only values 0..PAT_WIDTH-1 exist; there is no "full match" state.
- Expected bit in state s is E(s) = PATTERN[PAT_WIDTH-1-s].
- Hold: when in_valid=0, state, out_moore (driven to 0) and match_count hold; out=0.
- Advance: in_valid=1, in==E(s), s<PAT_WIDTH-1 → s+1.
- Match: in_valid=1, in==E(s), s==PAT_WIDTH-1 → out=1 in the same cycle.
  - Next state: B if overlap=1, else 0. B = length of the longest proper prefix of PATTERN that is also a suffix (B=1 for 1011, B=2 for 111).
  - out_moore=1 in the following cycle.
  - match_count increments unless already all-ones; it saturates and never wraps.
- Mismatch: in_valid=1, in!=E(s) → next state = longest k≤s such that the first k pattern bits equal the last k bits of (matched prefix of length s, followed by in). k may be 0.
- Mismatch fallback and B are computed at elaboration (constant function / generate). No runtime pattern search.
- overlap is sampled on the match cycle only; changing it mid-sequence affects the next match only.
- cnt_clr=1: match_count←0 next edge.
- cnt_clr and a match in the same cycle: clear wins and count becomes 0. out and out_moore are unaffected.
- rst has priority over everything.
- Reset mid-sequence discards any partial prefix; detection restarts from s=0 on the first valid bit after rst deasserts.
- out_moore is high for exactly one cycle per match. Back-to-back matches give consecutive out_moore highs.
- Latency: out has 0 cycles from the final pattern bit; out_moore has 1 cycle.

Test Plan:
1. Default params, overlap=0, in_valid=1; after reset drive 0,0,1,0,1,1,0,1,1,1,0,1,1,0,0,0 (index 0..15) → out high on index 5 and 12 only; out_moore high on index 6 and 13; final match_count=2.
2. Same stream, overlap=1 → out high on index 5, 8, 12; final match_count=3; state=1 in the cycle after each match.
3. PAT_WIDTH=3, PATTERN=3'b111, stream of six 1s.
   - overlap=0 → out on bits 3 and 6, count=2.
   - overlap=1 → out on bits 3,4,5,6, count=4.
4. Default params, stream 1,0,1,1 with in_valid=0 cycles inserted after every bit (in toggled randomly while invalid) → exactly one match on the 4th valid bit; state holds across invalid cycles; out=0 on invalid cycles.
5. CNT_WIDTH=2, overlap=1, stream 1011011011011011 (5 matches) → match_count saturates at 3.
   - cnt_clr asserted in the cycle of a further match → match_count=0 next cycle, while out=1 that cycle.
6. Drive 1,0,1, assert rst one cycle, deassert, then drive 1 → no match (state=1 after that bit).
   - Then drive 0,1,1 → match on the last bit; match_count=1.

Source files
------------

// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector with run-time overlap select,
// Mealy/Moore match flags and a saturating match counter.
module seq_detector_param #(
    parameter int unsigned           PAT_WIDTH = 4,
    parameter logic [PAT_WIDTH-1:0]  PATTERN   = 4'b1011,
    parameter int unsigned           CNT_WIDTH = 8,
    localparam int unsigned          SW        = $clog2(PAT_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in,
    input  logic                 in_valid,
    input  logic                 overlap,
    input  logic                 cnt_clr,
    output logic                 out,
    output logic                 out_moore,
    output logic [CNT_WIDTH-1:0] match_count,
    output logic [SW-1:0]        state
);

    localparam int unsigned NS   = 2 ** SW;
    localparam int unsigned LAST = PAT_WIDTH - 1;

    // Longest k <= s such that the first k pattern bits end the sequence
    // (first s pattern bits, then b).
    function automatic int unsigned fallback(input int unsigned s, input logic b);
        logic [16:0]  seq;
        int unsigned  best;
        logic         ok;
        seq  = '0;
        best = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i < s) seq[i] = PATTERN[PAT_WIDTH-1-i];
        end
        seq[s] = b;
        for (int unsigned k = 1; k <= s; k++) begin
            ok = 1'b1;
            for (int unsigned j = 0; j < k; j++) begin
                if (PATTERN[PAT_WIDTH-1-j] != seq[s+1-k+j]) ok = 1'b0;
            end
            if (ok) best = k;
        end
        return best;
    endfunction

    // Longest proper prefix of the pattern that is also a suffix.
    function automatic int unsigned border();
        int unsigned  best;
        logic         ok;
        best = 0;
        for (int unsigned k = 1; k < PAT_WIDTH; k++) begin
            ok = 1'b1;
            for (int unsigned j = 0; j < k; j++) begin
                if (PATTERN[PAT_WIDTH-1-j] != PATTERN[k-1-j]) ok = 1'b0;
            end
            if (ok) best = k;
        end
        return best;
    endfunction

    localparam int unsigned BORDER = border();

    logic          exp_tbl  [NS];
    logic [SW-1:0] fail_tbl [NS];

    // Per-state expected bit and mismatch target, fixed at elaboration.
    for (genvar g = 0; g < NS; g++) begin : g_tbl
        if (g < PAT_WIDTH) begin : g_live
            localparam int unsigned FB = fallback(g, ~PATTERN[PAT_WIDTH-1-g]);
            assign exp_tbl[g]  = PATTERN[PAT_WIDTH-1-g];
            assign fail_tbl[g] = SW'(FB);
        end else begin : g_dead
            assign exp_tbl[g]  = 1'b0;
            assign fail_tbl[g] = '0;
        end
    end

    logic [SW-1:0]        state_nxt;
    logic                 match;
    logic [CNT_WIDTH-1:0] count_nxt;

    always_comb begin
        state_nxt = state;
        match     = 1'b0;
        count_nxt = match_count;
        if (in_valid) begin
            if (in == exp_tbl[state]) begin
                if (state == SW'(LAST)) begin
                    match     = 1'b1;
                    state_nxt = overlap ? SW'(BORDER) : '0;
                end else begin
                    state_nxt = state + SW'(1);
                end
            end else begin
                state_nxt = fail_tbl[state];
            end
        end
        // Clear beats a coincident match; counter saturates at all-ones.
        if (cnt_clr) begin
            count_nxt = '0;
        end else if (match && (match_count != '1)) begin
            count_nxt = match_count + CNT_WIDTH'(1);
        end
    end

    assign out = match & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= '0;
            out_moore   <= 1'b0;
            match_count <= '0;
        end else begin
            state       <= state_nxt;
            out_moore   <= match;
            match_count <= count_nxt;
        end
    end

endmodule
